accumulate_unit: RTL

Sequential signed accumulator that sits directly downstream of the 32-bit `simpleAdder` combinational stage. It instantiates `simpleAdder` internally and feeds back its registered sum. It accepts a burst of `len` signed operands over a valid/ready stream, sums them one per cycle, and tracks overflow as a sticky flag with optional saturation. The total is presented on a valid/ready result port. This is the first clocked block in the adder family and the building block for later multi-operand and MAC datapaths.

---
 rtl/accumulate_unit.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/accumulate_unit.sv
// ---------------------------------------------------------------------------
// accumulate_unit
//
// Sequential signed accumulator built around the simpleAdder combinational
// stage. A burst of len_i signed operands is accepted over a valid/ready
// stream, one operand per cycle. Each accepted operand is summed into a
// running total. Two's-complement overflow is recorded in a sticky flag. The
// total either wraps on overflow or clamps to the most positive or most
// negative value. The final total is offered on a valid/ready result port.
//
// Ports
//   clk_i             : clock; all state changes on its rising edge
//   rst_i             : synchronous active-high reset, highest priority
//   start_i           : begin a burst (looked at only while idle)
//   len_i             : operand count for the burst, captured with start_i
//   saturate_i        : 1 = clamp on overflow, 0 = wrap; captured with start_i
//   in_valid_i        : operand valid
//   in_data_i         : signed operand
//   in_ready_o        : operand accepted when in_valid_i & in_ready_o
//   out_valid_o       : result valid
//   out_ready_i       : result consumed when out_valid_o & out_ready_i
//   acc_out_o         : accumulator register (last result while idle)
//   overflow_sticky_o : an accepted beat of the current/last burst overflowed
//   busy_o            : high whenever the unit is not idle
//
// simpleAdder (also in this file)
//   x_i, y_i   : addends
//   sum_o      : wrapped sum
//   carry_o    : unsigned carry out
//   overflow_o : signed (two's-complement) overflow
// ---------------------------------------------------------------------------

module simpleAdder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o
);

  logic [WIDTH:0] fullSum;

  assign fullSum = {1'b0, x_i} + {1'b0, y_i};
  assign sum_o   = fullSum[WIDTH-1:0];
  assign carry_o = fullSum[WIDTH];

  // Signed overflow: both addends share a sign that the result does not.
  assign overflow_o = (x_i[WIDTH-1] == y_i[WIDTH-1]) &&
                      (sum_o[WIDTH-1] != x_i[WIDTH-1]);

endmodule

module accumulate_unit #(
  parameter int WIDTH   = 32,
  parameter int COUNT_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [COUNT_W-1:0] len_i,
  input  logic               saturate_i,
  input  logic               in_valid_i,
  input  logic [WIDTH-1:0]   in_data_i,
  output logic               in_ready_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [WIDTH-1:0]   acc_out_o,
  output logic               overflow_sticky_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]   MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]   MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [COUNT_W-1:0] ONE     = COUNT_W'(1);

  state_t             state_q;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   acc_d;
  logic [COUNT_W-1:0] remaining_q;
  logic               sticky_q;
  logic               saturate_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;

  logic [WIDTH-1:0]   adderSum;
  logic               adderOverflow;
  logic               adder_carry_unused;

  // The accumulator register feeds back into x; the incoming operand is y.
  simpleAdder #(.WIDTH(WIDTH)) u_adder (
    .x_i        (acc_q),
    .y_i        (in_data_i),
    .sum_o      (adderSum),
    .carry_o    (adder_carry_unused),
    .overflow_o (adderOverflow)
  );

  // Next accumulator value for an accepted beat. On overflow in clamp mode
  // the direction comes from the operand's sign: a signed overflow can only
  // occur when both addends share that sign.
  always_comb begin
    acc_d = adderSum;
    if (adderOverflow && saturate_q) begin
      acc_d = in_data_i[WIDTH-1] ? MAX_NEG : MAX_POS;
    end
  end

  // Control FSM and datapath registers. The handshake outputs and busy are
  // registered together with the state so they never depend combinationally
  // on in_valid_i or out_ready_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      remaining_q <= '0;
      sticky_q    <= 1'b0;
      saturate_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            acc_q      <= '0;
            sticky_q   <= 1'b0;
            saturate_q <= saturate_i;
            busy_q     <= 1'b1;
            if (len_i != '0) begin
              remaining_q <= len_i;
              state_q     <= ACCUM;
              in_ready_q  <= 1'b1;
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end
          end
        end

        ACCUM: begin
          if (in_valid_i) begin
            acc_q       <= acc_d;
            remaining_q <= remaining_q - ONE;
            if (adderOverflow) begin
              sticky_q <= 1'b1;
            end
            if (remaining_q == ONE) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end

        DONE: begin
          if (out_ready_i) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end

        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o        = in_ready_q;
  assign out_valid_o       = out_valid_q;
  assign busy_o            = busy_q;
  assign acc_out_o         = acc_q;
  assign overflow_sticky_o = sticky_q;

endmodule
